exec_unit_hs: RTL

Parametrised successor to the core's single-cycle execute stage. Sits between decode and writeback/memory, with valid/ready handshakes on both sides so the pipeline can stall. Adds load/store address generation and branch/jump redirect with misalignment flagging. An optional iterative multiply/divide path makes it multi-cycle.

---
 rtl/exec_pkg.sv | 47 ++++
 rtl/exec_muldiv.sv | 81 ++++++++
 rtl/exec_unit_hs.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: func3 codes, FSM states, op-class priority.
package exec_pkg;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic {IDLE, BUSY} state_e;

    typedef enum logic [2:0] {
        CLS_NOP, CLS_ALU, CLS_MULDIV, CLS_JUMP, CLS_BRANCH, CLS_LOAD, CLS_STORE
    } class_e;

    // Several decode flags may be set at once; the highest-priority class wins.
    function automatic class_e op_class(input logic st, input logic ld, input logic br,
                                        input logic jp, input logic md, input logic alu);
        if (st)       return CLS_STORE;
        else if (ld)  return CLS_LOAD;
        else if (br)  return CLS_BRANCH;
        else if (jp)  return CLS_JUMP;
        else if (md)  return CLS_MULDIV;
        else if (alu) return CLS_ALU;
        else          return CLS_NOP;
    endfunction

endpackage

// File: rtl/exec_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Latency: start cycle plus XLEN steps; done pulses on the final step with result valid.
// Backpressure: none; the caller only starts it when its output register is free.
module exec_muldiv
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    logic              busy;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, acc_nxt, acc_mul, acc_div, prod;
    logic [XLEN-1:0]   opnd, a_abs, b_abs, div_val;
    logic [2:0]        f3_q;
    logic              neg_q, neg_d, a_sgn, b_sgn;
    logic [XLEN:0]     mul_sum, div_sh;
    logic [XLEN+1:0]   div_diff;
    logic              qbit;

    always_comb begin
        a_sgn = a[XLEN-1] & (func3 == MD_MULH || func3 == MD_MULHSU ||
                             func3 == MD_DIV  || func3 == MD_REM);
        b_sgn = b[XLEN-1] & (func3 == MD_MULH || func3 == MD_DIV || func3 == MD_REM);
        a_abs = a_sgn ? -a : a;
        b_abs = b_sgn ? -b : b;
        // Remainder takes the dividend's sign; a zero divisor keeps the all-ones quotient.
        if (!func3[2])     neg_d = a_sgn ^ b_sgn;
        else if (func3[1]) neg_d = a_sgn;
        else               neg_d = (a_sgn ^ b_sgn) & (b != '0);
    end

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        acc_mul  = {mul_sum, acc[XLEN-1:1]};
        div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff = {1'b0, div_sh} - {2'b00, opnd};
        qbit     = ~div_diff[XLEN+1];
        acc_div  = {(qbit ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), acc[XLEN-2:0], qbit};
        acc_nxt  = f3_q[2] ? acc_div : acc_mul;
        prod     = neg_q ? -acc_nxt : acc_nxt;
        div_val  = f3_q[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
        if (f3_q[2])              result = neg_q ? -div_val : div_val;
        else if (f3_q == MD_MUL)  result = prod[XLEN-1:0];
        else                      result = prod[2*XLEN-1:XLEN];
    end

    assign done = busy & (cnt == CW'(XLEN-1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy  <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            opnd  <= '0;
            f3_q  <= '0;
            neg_q <= 1'b0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            acc   <= {{XLEN{1'b0}}, a_abs};
            opnd  <= b_abs;
            f3_q  <= func3;
            neg_q <= neg_d;
        end else if (busy) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/exec_unit_hs.sv
// Execute stage with valid/ready on both sides: ALU, AGU, branch/jump redirect, optional muldiv (EXEC_MULDIV_EN).
// Latency: 1 cycle; muldiv (when EXEC_MULDIV_EN defined) XLEN+1 cycles from accept.
// Backpressure: output registers hold while out_valid & !out_ready; in_ready only when idle and output free.
module exec_unit_hs
    import exec_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            is_store,
    input  logic            is_load,
    input  logic            is_branch,
    input  logic            is_jump,
    input  logic            is_reg,
    input  logic            is_alu,
    input  logic            is_muldiv,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [XLEN-1:0] offset,
    input  logic [4:0]      dest_i,
    input  logic [2:0]      func3,
    input  logic            func7,
    input  logic [XLEN-1:0] curr_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      dest_o,
    output logic [XLEN-1:0] next_pc,
    output logic            redirect,
    output logic            misaligned,
    output logic            mem_re,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [2:0]      mem_size,
    output logic            illegal
);
    localparam int SHW = $clog2(XLEN);

    state_e          state_q, state_d;
    class_e          cls;
    logic            accept, load_ex, md_start, md_done;
    logic [XLEN-1:0] pc4, tgt, agu, jmp_pc, alu_res, md_result;
    logic [SHW-1:0]  shamt;
    logic            br_take, br_ill;
    logic            redirect_q, mem_re_q, mem_we_q;

    logic [XLEN-1:0] n_result, n_pc, n_addr, n_wdata;
    logic [4:0]      n_dest;
    logic            n_redir, n_mis, n_re, n_we, n_ill;

    assign cls      = op_class(is_store, is_load, is_branch, is_jump, is_muldiv, is_alu);
    assign in_ready = (state_q == IDLE) & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign pc4      = curr_pc + XLEN'(4);
    assign tgt      = curr_pc + offset;
    assign agu      = operand_a + offset;
    assign jmp_pc   = is_reg ? {agu[XLEN-1:1], 1'b0} : tgt;
    assign shamt    = operand_b[SHW-1:0];

    assign redirect = redirect_q & out_valid;
    assign mem_re   = mem_re_q & out_valid;
    assign mem_we   = mem_we_q & out_valid;

    always_comb begin
        case (func3)
            F3_ADD:  alu_res = func7 ? operand_a - operand_b : operand_a + operand_b;
            F3_SLL:  alu_res = operand_a << shamt;
            F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            F3_XOR:  alu_res = operand_a ^ operand_b;
            F3_SR:   alu_res = func7 ? $unsigned($signed(operand_a) >>> shamt) : operand_a >> shamt;
            F3_OR:   alu_res = operand_a | operand_b;
            default: alu_res = operand_a & operand_b;
        endcase
    end

    always_comb begin
        br_take = 1'b0;
        br_ill  = 1'b0;
        case (func3)
            BR_BEQ:  br_take = operand_a == operand_b;
            BR_BNE:  br_take = operand_a != operand_b;
            BR_BLT:  br_take = $signed(operand_a) < $signed(operand_b);
            BR_BGE:  br_take = $signed(operand_a) >= $signed(operand_b);
            BR_BLTU: br_take = operand_a < operand_b;
            BR_BGEU: br_take = operand_a >= operand_b;
            default: br_ill  = 1'b1;
        endcase
    end

    always_comb begin
        n_result = '0;
        n_dest   = '0;
        n_pc     = pc4;
        n_redir  = 1'b0;
        n_mis    = 1'b0;
        n_re     = 1'b0;
        n_we     = 1'b0;
        n_addr   = '0;
        n_wdata  = '0;
        n_ill    = 1'b0;
        case (cls)
            CLS_STORE: begin
                n_we    = 1'b1;
                n_addr  = agu;
                n_wdata = operand_b;
            end
            CLS_LOAD: begin
                n_re   = 1'b1;
                n_addr = agu;
                n_dest = dest_i;
            end
            CLS_BRANCH: begin
                n_ill = br_ill;
                if (br_take && !br_ill) begin
                    n_redir = 1'b1;
                    n_pc    = tgt;
                    n_mis   = tgt[1];
                end
            end
            CLS_JUMP: begin
                n_result = pc4;
                n_redir  = 1'b1;
                n_pc     = jmp_pc;
                n_mis    = jmp_pc[1];
                // A misaligned target traps, so the link register must not be written.
                n_dest   = jmp_pc[1] ? 5'd0 : ((dest_i == 5'd0) ? 5'd1 : dest_i);
            end
            CLS_MULDIV: begin
`ifndef EXEC_MULDIV_EN
                n_ill = 1'b1;
`endif
            end
            CLS_ALU: begin
                n_result = alu_res;
                n_dest   = dest_i;
            end
            default: ;
        endcase
    end

`ifdef EXEC_MULDIV_EN
    logic [4:0]      md_dest;
    logic [XLEN-1:0] md_pc4;

    assign md_start = accept & (cls == CLS_MULDIV);
    assign load_ex  = accept & (cls != CLS_MULDIV);

    exec_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (md_start),
        .func3   (func3),
        .a       (operand_a),
        .b       (operand_b),
        .done    (md_done),
        .result  (md_result)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_dest <= '0;
            md_pc4  <= '0;
        end else if (md_start) begin
            md_dest <= dest_i;
            md_pc4  <= pc4;
        end
    end
`else
    assign md_start  = 1'b0;
    assign md_done   = 1'b0;
    assign md_result = '0;
    assign load_ex   = accept;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (md_start) state_d = BUSY;
            BUSY:    if (md_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            result     <= '0;
            dest_o     <= '0;
            next_pc    <= RESET_PC;
            redirect_q <= 1'b0;
            misaligned <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_size   <= '0;
            illegal    <= 1'b0;
        end else if (load_ex) begin
            out_valid  <= 1'b1;
            result     <= n_result;
            dest_o     <= n_dest;
            next_pc    <= n_pc;
            redirect_q <= n_redir;
            misaligned <= n_mis;
            mem_re_q   <= n_re;
            mem_we_q   <= n_we;
            mem_addr   <= n_addr;
            mem_wdata  <= n_wdata;
            mem_size   <= func3;
            illegal    <= n_ill;
        end else if (md_done && state_q == BUSY) begin
`ifdef EXEC_MULDIV_EN
            out_valid  <= 1'b1;
            result     <= md_result;
            dest_o     <= md_dest;
            next_pc    <= md_pc4;
            redirect_q <= 1'b0;
            misaligned <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            illegal    <= 1'b0;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
